// File: rtl/image_filter_engine.sv
// Avalon-MM KxK grayscale image filter: pixel window -> luma -> kernel MAC -> clamped result.
// Define IMAGE_FILTER_THRESHOLD_EN to add the THRESH register (0x3F) and binarise the result.
//   state | meaning
//   IDLE  | collecting pixel writes, bus fully open
//   GRAY  | convert every stored pixel to luma, latch mode
//   ACCUM | add one signed kernel term per cycle, index 0 upward
//   FINAL | scale, clamp, publish result, set done
module image_filter_engine #(
   parameter int BIT_PER_PIXEL = 8,
   parameter int KERNEL_DIM    = 3,
   parameter int ADDR_WIDTH    = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read,
   output logic [31:0]           readdata,
   input  logic                  write,
   input  logic [31:0]           writedata,
   output logic                  waitrequest,
   output logic                  irq
);
   localparam int NUM_PIXELS = KERNEL_DIM * KERNEL_DIM;
   localparam int CENTRE     = NUM_PIXELS / 2;
   localparam int ACC_W      = BIT_PER_PIXEL + 12;
   localparam int PROD_W     = ACC_W + 18;
   localparam int IDX_W      = $clog2(NUM_PIXELS);
   localparam int GW         = BIT_PER_PIXEL + 8;
   localparam int RECIP      = (65536 + NUM_PIXELS - 1) / NUM_PIXELS;
   localparam logic signed [ACC_W-1:0]  EDGE_GAIN = ACC_W'(NUM_PIXELS - 1);
   localparam logic signed [PROD_W-1:0] RECIP_W   = PROD_W'(RECIP);
   localparam logic signed [PROD_W-1:0] MAX_W     = PROD_W'((1 << BIT_PER_PIXEL) - 1);
   localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(6'h3C);
   localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(6'h3D);
   localparam logic [ADDR_WIDTH-1:0] A_RES  = ADDR_WIDTH'(6'h3E);
   localparam logic [ADDR_WIDTH-1:0] A_THR  = ADDR_WIDTH'(6'h3F);

   typedef enum logic [1:0] {IDLE, GRAY, ACCUM, FINAL} state_t;

   state_t                   state;
   logic [NUM_PIXELS-1:0]    mask, pix_bit;
   logic [1:0]               mode, mode_lat;
   logic [BIT_PER_PIXEL-1:0] pix_r [NUM_PIXELS];
   logic [BIT_PER_PIXEL-1:0] pix_g [NUM_PIXELS];
   logic [BIT_PER_PIXEL-1:0] pix_b [NUM_PIXELS];
   logic [BIT_PER_PIXEL-1:0] y     [NUM_PIXELS];
   logic [IDX_W-1:0]         idx, pix_idx;
   logic signed [ACC_W-1:0]  acc, term, y_ext;
   logic signed [PROD_W-1:0] acc_ext, y_c, mean, value;
   logic [BIT_PER_PIXEL-1:0] clamped, final_out, result;
   logic                     done, busy, pix_sel;
   logic [7:0]               pop;
   logic                     unused_bits;
`ifdef IMAGE_FILTER_THRESHOLD_EN
   logic [BIT_PER_PIXEL-1:0] thresh;
`endif

   assign busy        = (state != IDLE);
   assign irq         = done;
   assign waitrequest = busy && (write || (read && address == A_RES));
   assign pix_sel     = address < ADDR_WIDTH'(NUM_PIXELS);
   assign pix_idx     = IDX_W'(address);
   assign pix_bit     = NUM_PIXELS'(1) << pix_idx;
   assign unused_bits = ^writedata;

   function automatic logic [BIT_PER_PIXEL-1:0] gray(input logic [BIT_PER_PIXEL-1:0] r,
                                                     input logic [BIT_PER_PIXEL-1:0] g,
                                                     input logic [BIT_PER_PIXEL-1:0] b);
      logic [GW-1:0] sum;
      sum = GW'(77) * GW'(r) + GW'(150) * GW'(g) + GW'(29) * GW'(b);
      return sum[GW-1:8];
   endfunction

   // Blur and sharpen accumulate the plain luma sum; scaling happens in FINAL.
   always_comb begin
      y_ext = ACC_W'(y[idx]);
      term  = y_ext;
      case (mode_lat)
         2'd0:    term = (idx == IDX_W'(CENTRE)) ? y_ext : '0;
         2'd1:    term = (idx == IDX_W'(CENTRE)) ? EDGE_GAIN * y_ext : -y_ext;
         default: term = y_ext;
      endcase
   end

   always_comb begin
      acc_ext = PROD_W'(acc);
      y_c     = PROD_W'(y[CENTRE]);
      mean    = (acc_ext * RECIP_W) >>> 16;
      case (mode_lat)
         2'd2:    value = mean;
         2'd3:    value = (y_c <<< 1) - mean;
         default: value = acc_ext;
      endcase
      if (value < 0)          clamped = '0;
      else if (value > MAX_W) clamped = '1;
      else                    clamped = value[BIT_PER_PIXEL-1:0];
`ifdef IMAGE_FILTER_THRESHOLD_EN
      final_out = (clamped >= thresh) ? '1 : '0;
`else
      final_out = clamped;
`endif
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_PIXELS; i++) pop = pop + 8'(mask[i]);
   end

   always_comb begin
      readdata = '0;
      case (address)
         A_CTRL: readdata[1:0] = mode;
         A_STAT: begin
            readdata[0]    = busy;
            readdata[1]    = done;
            readdata[15:8] = pop;
         end
         A_RES:  readdata[BIT_PER_PIXEL-1:0] = result;
`ifdef IMAGE_FILTER_THRESHOLD_EN
         A_THR:  readdata[BIT_PER_PIXEL-1:0] = thresh;
`endif
         default: readdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         mask     <= '0;
         mode     <= '0;
         mode_lat <= '0;
         result   <= '0;
         done     <= 1'b0;
         idx      <= '0;
         acc      <= '0;
         for (int i = 0; i < NUM_PIXELS; i++) begin
            pix_r[i] <= '0;
            pix_g[i] <= '0;
            pix_b[i] <= '0;
            y[i]     <= '0;
         end
`ifdef IMAGE_FILTER_THRESHOLD_EN
         thresh   <= BIT_PER_PIXEL'(128);
`endif
      end else begin
         case (state)
            IDLE: begin
               if (read && address == A_RES) done <= 1'b0;
               if (write && pix_sel) begin
                  pix_r[pix_idx] <= writedata[BIT_PER_PIXEL-1:0];
                  pix_g[pix_idx] <= writedata[8 +: BIT_PER_PIXEL];
                  pix_b[pix_idx] <= writedata[16 +: BIT_PER_PIXEL];
                  done           <= 1'b0;
                  if ((mask | pix_bit) == '1) begin
                     mask  <= '0;
                     state <= GRAY;
                  end else begin
                     mask <= mask | pix_bit;
                  end
               end
               if (write && address == A_CTRL) begin
                  if (writedata[31]) mask <= '0;
                  else               mode <= writedata[1:0];
               end
`ifdef IMAGE_FILTER_THRESHOLD_EN
               if (write && address == A_THR) thresh <= writedata[BIT_PER_PIXEL-1:0];
`endif
            end
            GRAY: begin
               for (int i = 0; i < NUM_PIXELS; i++) y[i] <= gray(pix_r[i], pix_g[i], pix_b[i]);
               mode_lat <= mode;
               acc      <= '0;
               idx      <= '0;
               state    <= ACCUM;
            end
            ACCUM: begin
               acc <= acc + term;
               if (idx == IDX_W'(NUM_PIXELS - 1)) state <= FINAL;
               else                               idx   <= idx + 1'b1;
            end
            FINAL: begin
               result <= final_out;
               done   <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_image_filter_engine.sv
// Scoreboard bench for image_filter_engine: reads push expected data, a monitor pops on accepted reads.
module tb_image_filter_engine;
   localparam int BPP = 8, KD = 3, AW = 6, NP = KD * KD, CEN = NP / 2;
   localparam logic [AW-1:0] A_CTRL = 6'h3C, A_STAT = 6'h3D, A_RES = 6'h3E, A_THR = 6'h3F;

   logic          clk = 1'b0, reset_n = 1'b0;
   logic [AW-1:0] address = '0;
   logic          read = 1'b0, write = 1'b0;
   logic [31:0]   writedata = '0, readdata;
   logic          waitrequest, irq;

   int          n_checks = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   int          win_r[NP], win_g[NP], win_b[NP];
   int          thresh_val = 128;

   image_filter_engine #(.BIT_PER_PIXEL(BPP), .KERNEL_DIM(KD), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .read(read), .readdata(readdata),
      .write(write), .writedata(writedata), .waitrequest(waitrequest), .irq(irq));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (read && !waitrequest) begin
         if (exp_q.size() == 0) check("unexpected_read", readdata, 32'hDEAD_BEEF);
         else check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
   end

   // Reference: luma per pixel, then kernel arithmetic on plain integers.
   function automatic int model(input int mode);
      int yv[NP];
      int s, mean, v;
      s = 0;
      for (int i = 0; i < NP; i++) begin
         yv[i] = (77 * win_r[i] + 150 * win_g[i] + 29 * win_b[i]) / 256;
         s += yv[i];
      end
      mean = (s * ((65536 + NP - 1) / NP)) / 65536;
      case (mode)
         0:       v = yv[CEN];
         1:       v = (NP - 1) * yv[CEN] - (s - yv[CEN]);
         2:       v = mean;
         default: v = 2 * yv[CEN] - mean;
      endcase
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
`ifdef IMAGE_FILTER_THRESHOLD_EN
      v = (v >= thresh_val) ? 255 : 0;
`endif
      return v;
   endfunction

   function automatic logic [31:0] pix_word(input int i);
      return {8'h00, 8'(win_b[i]), 8'(win_g[i]), 8'(win_r[i])};
   endfunction

   task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, output int stalls);
      stalls = 0;
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      while (waitrequest) begin
         stalls++;
         if (stalls > 200) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout: addr 0x%0h stalled %0d cycles, required acceptance", a, stalls);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic bus_read(input logic [AW-1:0] a, input logic [31:0] exp, input string name,
                           output int stalls);
      stalls = 0;
      exp_q.push_back(exp); name_q.push_back(name);
      address = a; read = 1'b1;
      @(negedge clk);
      while (waitrequest) begin
         stalls++;
         if (stalls > 200) begin
            n_checks++; n_fail++;
            $display("FAIL read_timeout: addr 0x%0h stalled %0d cycles, required acceptance", a, stalls);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      int s;
      bus_write(a, d, s);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
      int s;
      bus_read(a, exp, name, s);
   endtask

   task automatic set_all(input int r, input int g, input int b);
      for (int i = 0; i < NP; i++) begin win_r[i] = r; win_g[i] = g; win_b[i] = b; end
   endtask

   task automatic set_px(input int i, input int r, input int g, input int b);
      win_r[i] = r; win_g[i] = g; win_b[i] = b;
   endtask

   task automatic write_pixels(input int order_kind, input bit overwrite);
      int order[NP];
      int p, j, t;
      for (int i = 0; i < NP; i++) order[i] = (order_kind == 1) ? NP - 1 - i : i;
      if (order_kind == 2)
         for (int i = NP - 1; i > 0; i--) begin
            j = $urandom_range(0, i); t = order[i]; order[i] = order[j]; order[j] = t;
         end
      p = $urandom_range(1, NP - 2);
      for (int k = 0; k < NP; k++) begin
         wr(AW'(order[k]), pix_word(order[k]));
         if (overwrite && k == p) begin
            set_px(order[0], $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            wr(AW'(order[0]), pix_word(order[0]));
         end
      end
   endtask

   task automatic run_window(input int mode, input int order_kind, input bit overwrite, input string tag);
      wr(A_CTRL, 32'(mode));
      write_pixels(order_kind, overwrite);
      repeat (NP + 1) @(posedge clk);
      #1 check({tag, "_irq_before_latency"}, 32'(irq), 0);
      @(posedge clk);
      #1 check({tag, "_irq_at_latency"}, 32'(irq), 1);
      rd(A_STAT, 32'h2, {tag, "_status_done"});
      rd(A_RES, 32'(model(mode)), {tag, "_result"});
      rd(A_STAT, 32'h0, {tag, "_status_cleared"});
      check({tag, "_irq_cleared"}, 32'(irq), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset_waitrequest", 32'(waitrequest), 0);
      check("reset_irq", 32'(irq), 0);
      rd(A_STAT, 32'h0, "reset_status");
      rd(A_RES, 32'h0, "reset_result");
      rd(A_CTRL, 32'h0, "reset_ctrl");
`ifdef IMAGE_FILTER_THRESHOLD_EN
      rd(A_THR, 32'h80, "reset_thresh");
`else
      rd(A_THR, 32'h0, "reset_thresh");
`endif
      rd(6'h00, 32'h0, "pixel_read_zero");
      wr(6'h20, 32'hFFFF_FFFF);
      rd(6'h20, 32'h0, "unmapped_read");
      rd(A_STAT, 32'h0, "unmapped_write_ignored");

      set_all(100, 100, 100);
      run_window(0, 1, 0, "pass_100_rev");
      set_all(0, 0, 0); set_px(CEN, 200, 200, 200);
      run_window(1, 0, 0, "edge_pos_clamp");
      set_all(255, 255, 255); set_px(CEN, 0, 0, 0);
      run_window(1, 2, 0, "edge_neg_clamp");
      set_all(100, 100, 100);
      run_window(2, 2, 0, "blur_100");
      set_all(100, 100, 100); set_px(CEN, 200, 200, 200);
      run_window(3, 0, 0, "sharpen_clamp");
      set_all(0, 0, 0); set_px(CEN, 255, 0, 0);
      run_window(0, 0, 0, "pass_red");

      // RESULT read issued mid-ACCUM stalls through FINAL, then returns the new value.
      set_all(0, 0, 0); set_px(CEN, 255, 0, 0);
      wr(A_CTRL, 32'h0);
      write_pixels(0, 0);
      repeat (3) @(posedge clk); #1;
      bus_read(A_RES, 32'(model(0)), "stalled_result", st);
      check("stalled_result_cycles", 32'(st), 32'(NP + 2 - 3));
      check("stalled_result_clears_done", 32'(irq), 0);
      rd(A_STAT, 32'h0, "stalled_status");

      // A write right after the completing pixel stalls for the whole busy period.
      for (int i = 0; i < NP; i++) set_px(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      write_pixels(2, 0);
      bus_write(A_CTRL, 32'h1, st);
      check("busy_write_stall_cycles", 32'(st), 32'(NP + 2));
      rd(A_CTRL, 32'h1, "ctrl_after_stall");
      rd(A_RES, 32'(model(0)), "result_old_mode");

      // Partial window then mask clear.
      for (int i = 0; i < 5; i++) wr(AW'(i), pix_word(i));
      rd(A_STAT, 32'h0000_0500, "mask_count_5");
      wr(A_CTRL, 32'h8000_0000);
      rd(A_STAT, 32'h0, "mask_cleared");
      rd(A_CTRL, 32'h1, "mode_kept_on_clear");
      set_all(0, 0, 0); set_px(CEN, 200, 200, 200);
      for (int i = 0; i < NP - 1; i++) wr(AW'(i), pix_word(i));
      rd(A_STAT, 32'h0000_0800, "mask_count_8");
      wr(AW'(NP - 1), pix_word(NP - 1));
      repeat (NP + 2) @(posedge clk); #1;
      rd(A_STAT, 32'h2, "edge_after_clear_done");
      // Pixel write while done begins a new window and drops done.
      wr(6'h00, pix_word(0));
      rd(A_STAT, 32'h0000_0100, "pixel_write_clears_done");
      check("pixel_write_clears_irq", 32'(irq), 0);
      for (int i = 1; i < NP; i++) wr(AW'(i), pix_word(i));
      repeat (NP + 2) @(posedge clk); #1;
      rd(A_RES, 32'(model(1)), "edge_after_clear_result");

      for (int n = 0; n < 20; n++) run_window($urandom_range(0, 3), 2, 1'($urandom_range(0, 1)), "random");

`ifdef IMAGE_FILTER_THRESHOLD_EN
      wr(A_THR, 32'd50);
      thresh_val = 50;
      rd(A_THR, 32'd50, "thresh_readback");
      set_all(0, 0, 0); set_px(CEN, 255, 0, 0);
      run_window(0, 0, 0, "thresh_red");
`else
      wr(A_THR, 32'd50);
      rd(A_THR, 32'h0, "thresh_absent");
`endif

      // Reset during ACCUM aborts everything.
      set_all(100, 100, 100);
      wr(A_CTRL, 32'h2);
      write_pixels(0, 0);
      repeat (4) @(posedge clk); #1;
      reset_n = 1'b0;
      address = A_STAT;
      #2 check("status_in_reset", readdata, 32'h0);
      check("irq_in_reset", 32'(irq), 0);
      @(negedge clk) reset_n = 1'b1;
      thresh_val = 128;
      @(posedge clk); #1;
      rd(A_STAT, 32'h0, "status_after_abort");
      rd(A_RES, 32'h0, "result_after_abort");
      rd(A_CTRL, 32'h0, "ctrl_after_abort");

      repeat (3) @(posedge clk); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
